mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Memory-stage load/store unit for the 5-stage RV32I pipeline. It sits between the EX/MEM register and the MEM/WB register.
- Converts the M-stage access into a req/ack data-bus transaction.
- Stalls the pipeline until the access completes.
- Produces the sign/zero-extended load value `rdata` that the MEM/WB register captures.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16, max cycles to wait for dmem_ack before aborting; must be >= 1.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  synchronous reset, active-high.
- rd_enM  in  1  load in M stage.
- wr_enM  in  1  store in M stage; rd_enM and wr_enM are never both 1.
- funct3M  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- ALUResultM  in  32  byte address.
- rdata2M  in  32  store source register value.
- dmem_req  out  1  bus request; held until ack or timeout.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address; bits [1:0] = 0.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  bus completion; valid only while dmem_req = 1.
- dmem_rdata  in  32  read word; valid with dmem_ack.
- rdata  out  32  extended load result, to MEM/WB register.
- stallM  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; MEM/WB is not frozen.
- misalignM  out  1  misaligned access, combinational.
- bus_errM  out  1  one-cycle pulse when a timeout abort occurs.

Behaviour:
- **Access decode:** access = rd_enM | wr_enM.
- **Misalignment:**
  - Halfword with addr[0] = 1, or word with addr[1:0] != 0, sets misalignM = 1.
  - A misaligned access issues no bus request and never stalls.
  - Its rdata = 0; stores to that address are dropped.
- **FSM states:** IDLE, REQ, DONE. Reset: state = IDLE, dmem_req = 0, counter = 0, captured data = 0, bus_errM = 0.
- **IDLE:**
  - If access and not misaligned: register dmem_req = 1, dmem_we = wr_enM, addr/wdata/be, then go to REQ.
  - stallM = 1 in this cycle.
- **REQ:**
  - stallM = 1; the counter increments each cycle.
  - If dmem_ack = 1: capture dmem_rdata, drop dmem_req at the next edge, go to DONE.
  - Else if counter reaches TIMEOUT - 1: drop dmem_req, capture 0, pulse bus_errM for one cycle, go to DONE.
  - Bus outputs stay stable while in REQ.
- **DONE:**
  - stallM = 0 for exactly one cycle; the MEM/WB register latches rdata; the M instruction retires.
  - Go to IDLE. The counter is cleared.
- **Latency:** minimum 3 cycles per access (IDLE, REQ with same-cycle ack, DONE). Non-access instructions take 1 cycle with no stall.
- **Store lanes (be / wdata):**
  - SB: be = 1 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
  - SW: be = 1111; wdata = rs2.
  - be = 0000 when dmem_we = 0.
- **Load extraction:**
  - Extraction is taken from the captured word using the lane given by addr.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - rdata = 0 whenever not in DONE, or when the access is not a load.
- **Late acknowledge:** a dmem_ack arriving in any state other than REQ is ignored.
- **Reset mid-transaction:** the next edge returns to IDLE with dmem_req = 0; an in-flight access is abandoned.
- **Inputs during stall:** held constant by the frozen EX/MEM register. The captured request is not re-sampled while in REQ.

Decomposition:
- Package mem_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State typedef enum {IDLE, REQ, DONE}.
- Sub-module lsu_align: a combinational block holding the store lane/byte-enable generator and the load extract/extend logic.
- The FSM, timeout counter and request registers stay in mem_stage_lsu.

Test Plan:
- LW at 0x100, dmem_rdata = 0xDEADBEEF, ack in the 1st REQ cycle -> stallM high for 2 cycles, dmem_addr = 0x100, be = 1111, rdata = 0xDEADBEEF in DONE.
- LB at 0x103, dmem_rdata = 0x80FF_FFFF -> rdata = 0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at 0x102 with 0x8001_0000 -> 0x00008001.
- SB rs2 = 0x000000AB at 0x201 -> dmem_we = 1, be = 0010, wdata = 0xABABABAB, dmem_addr = 0x200; SH at 0x202 -> be = 1100.
- LW at 0x102 -> misalignM = 1, dmem_req stays 0, stallM = 0, rdata = 0.
- TIMEOUT = 4, no ack -> dmem_req high for exactly 4 cycles, bus_errM pulses 1 cycle, rdata = 0, stall releases in DONE.
- rst asserted in the 2nd REQ cycle with ack pending -> next cycle state IDLE, dmem_req = 0, stallM = 0; a later ack is ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// - funct3 encodings for load/store size and signedness
// - FSM state type of mem_stage_lsu
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   cur_size   funct3[1:0] of the instruction now in M (00 byte, 01 half, 10 word)
//   cur_off    address bits [1:0] of the instruction now in M
//   st_we      store strobe; byte enables are zero when clear
//   st_src     store source register
//   st_be      byte enables for the bus
//   st_wdata   lane-replicated store data
//   misalign   halfword on an odd address or word not on a 4-byte boundary
//   ld_funct3  funct3 of the captured load
//   ld_off     address bits [1:0] of the captured load
//   ld_word    captured bus read word
//   ld_value   extracted and extended load value
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  cur_size,
  input  logic [1:0]  cur_off,
  input  logic        st_we,
  input  logic [31:0] st_src,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        misalign,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_value
);

  logic [31:0] shifted;

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = st_src;
    case (cur_size)
      2'b00: begin
        st_be    = 4'b0001 << cur_off;
        st_wdata = {4{st_src[7:0]}};
      end
      2'b01: begin
        st_be    = cur_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_src[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_src;
      end
    endcase
    if (!st_we) st_be = 4'b0000;
  end

  assign misalign = ((cur_size == 2'b01) && cur_off[0]) ||
                    ((cur_size == 2'b10) && (cur_off != 2'b00));

  // Bring the addressed lane down to bit 0, then extend.
  assign shifted = ld_word >> {ld_off, 3'b000};

  always_comb begin
    ld_value = shifted;
    case (ld_funct3)
      F3_B:    ld_value = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_value = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   ld_value = {24'h0, shifted[7:0]};
      F3_HU:   ld_value = {16'h0, shifted[15:0]};
      default: ld_value = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit for a 5-stage RV32I pipeline.
// Turns the M-stage access into a req/ack bus transaction, stalls the
// upstream pipeline until it completes and presents the extended load value
// to the MEM/WB register during the single DONE cycle.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rd_enM, wr_enM           load / store in M (mutually exclusive)
//   funct3M, ALUResultM      access size/sign and byte address
//   rdata2M                  store source
//   dmem_*                   data bus; dmem_req is held until ack or timeout
//   rdata                    load result, zero outside DONE or for stores
//   stallM                   freeze PC .. EX/MEM
//   misalignM                combinational misalignment flag
//   bus_errM                 one-cycle pulse after a timeout abort
//   state_dbg                current FSM state
// Handshake: dmem_req rises at the edge leaving IDLE and the request fields
// stay frozen while it is high; a cycle with dmem_req = 1 and dmem_ack = 1
// completes the transfer. dmem_ack outside REQ is ignored.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_enM,
  input  logic        wr_enM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] rdata2M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] rdata,
  output logic        stallM,
  output logic        misalignM,
  output logic        bus_errM,
  output state_t      state_dbg
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_q, we_q, ld_q, err_q;
  logic [31:0]       addr_q, wdata_q, word_q;
  logic [3:0]        be_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;

  logic              access, misal;
  logic              issue, ack_take, timeout;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata, ld_value;

  assign access = rd_enM | wr_enM;

  lsu_align u_align (
    .cur_size  (funct3M[1:0]),
    .cur_off   (ALUResultM[1:0]),
    .st_we     (wr_enM),
    .st_src    (rdata2M),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .misalign  (misal),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .ld_word   (word_q),
    .ld_value  (ld_value)
  );

  always_comb begin
    state_d  = state_q;
    stallM   = 1'b0;
    issue    = 1'b0;
    ack_take = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !misal) begin
          stallM  = 1'b1;
          issue   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stallM = 1'b1;
        // An ack on the final allowed cycle still wins over the timeout.
        if (dmem_ack) begin
          ack_take = 1'b1;
          state_d  = DONE;
        end else if (cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= timeout;
      if (state_q == REQ) cnt_q <= cnt_q + 1'b1;
      else                cnt_q <= '0;
      if (issue) begin
        req_q   <= 1'b1;
        we_q    <= wr_enM;
        ld_q    <= rd_enM;
        addr_q  <= {ALUResultM[31:2], 2'b00};
        wdata_q <= st_wdata;
        be_q    <= st_be;
        f3_q    <= funct3M;
        off_q   <= ALUResultM[1:0];
      end
      if (ack_take) begin
        req_q  <= 1'b0;
        word_q <= dmem_rdata;
      end
      if (timeout) begin
        req_q  <= 1'b0;
        word_q <= '0;
      end
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign rdata      = (state_q == DONE && ld_q) ? ld_value : 32'h0;
  assign misalignM  = access & misal;
  assign bus_errM   = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
  import mem_pkg::*;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rd_enM = 1'b0, wr_enM = 1'b0;
  logic [2:0]  funct3M = 3'b0;
  logic [31:0] ALUResultM = '0, rdata2M = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] rdata;
  logic        stallM, misalignM, bus_errM;
  state_t      state_dbg;

  mem_stage_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rd_enM(rd_enM), .wr_enM(wr_enM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .rdata2M(rdata2M), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .rdata(rdata), .stallM(stallM), .misalignM(misalignM), .bus_errM(bus_errM),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [68:0] bus_q[$];   // {we, addr, be, wdata}
  logic [32:0] ret_q[$];   // {rdata, bus_err}

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off, input logic we);
    int size;
    logic [3:0] be;
    size = acc_size(f3);
    be = 4'b0;
    for (int i = 0; i < 4; i++)
      if (we && i >= int'(off) && i < int'(off) + size) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    int size;
    logic [31:0] wd;
    size = acc_size(f3);
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = rs2[8*(i % size) +: 8];
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word);
    int size;
    logic [31:0] v;
    logic [31:0] mask;
    size = acc_size(f3);
    v = word >> (8 * int'(off));
    if (size < 4) begin
      mask = (32'h1 << (8 * size)) - 32'h1;
      v = v & mask;
      if (!f3[2] && v[8*size-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic push_bus(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2);
    bus_q.push_back({wr, addr & 32'hFFFF_FFFC, model_be(f3, addr[1:0], wr),
                     wr ? model_wdata(f3, rs2) : 32'h0});
  endtask

  // ---------------- monitor ----------------
  logic        prev_req = 1'b0, prev_stall = 1'b0, prev_rst = 1'b1;
  logic [68:0] prev_bus = '0;
  always @(negedge clk) begin
    logic [68:0] cur_bus;
    logic [68:0] exp_bus;
    logic [32:0] exp_ret;
    cur_bus = {dmem_we, dmem_addr, dmem_be, dmem_we ? dmem_wdata : 32'h0};
    if (!rst) begin
      if (dmem_req && !prev_req) begin
        if (bus_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL bus_req: request %h with no expected request", cur_bus);
        end else begin
          exp_bus = bus_q.pop_front();
          check("bus_req", cur_bus, exp_bus);
        end
      end else if (dmem_req && prev_req) begin
        check("bus_stable", cur_bus, prev_bus);
      end
      if (stallM) begin
        check("rdata_during_stall", 69'(rdata), 69'(0));
        check("bus_err_during_stall", 69'(bus_errM), 69'(0));
      end else if (prev_stall && !prev_rst) begin
        if (ret_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL retire: stall release with no expected result, rdata %h", rdata);
        end else begin
          exp_ret = ret_q.pop_front();
          check("retire", 69'({rdata, bus_errM}), 69'(exp_ret));
        end
      end
    end
    prev_req   = dmem_req;
    prev_stall = stallM;
    prev_rst   = rst;
    prev_bus   = cur_bus;
  end

  // ---------------- driver ----------------
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2,
                           input int delay, input logic no_ack, input logic [31:0] rword);
    int size, k, exp_cycles;
    logic mis, acked;
    size = acc_size(f3);
    rd_enM = rd; wr_enM = wr; funct3M = f3; ALUResultM = addr; rdata2M = rs2;
    mis = (rd | wr) && ((size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00));
    if (!(rd | wr) || mis) begin
      @(negedge clk);
      check("misalignM", 69'(misalignM), 69'(mis));
      check("no_stall", 69'(stallM), 69'(0));
      check("no_req", 69'(dmem_req), 69'(0));
      check("no_rdata", 69'(rdata), 69'(0));
      @(posedge clk); #1;
      rd_enM = 1'b0; wr_enM = 1'b0;
      return;
    end
    acked = !no_ack && delay < TIMEOUT;
    push_bus(wr, f3, addr, rs2);
    ret_q.push_back({(acked && rd) ? model_load(f3, addr[1:0], rword) : 32'h0, !acked});
    exp_cycles = acked ? delay + 1 : TIMEOUT;
    @(negedge clk);
    check("issue_stall", 69'(stallM), 69'(1));
    check("issue_misalign", 69'(misalignM), 69'(0));
    @(posedge clk); #1;
    k = 0;
    while (stallM && k < 40) begin
      dmem_ack   = !no_ack && (k == delay);
      dmem_rdata = dmem_ack ? rword : $urandom;
      @(posedge clk); #1;
      k++;
    end
    dmem_ack = 1'b0;
    check("req_cycles", 69'(k), 69'(exp_cycles));
    @(posedge clk); #1;
    rd_enM = 1'b0; wr_enM = 1'b0;
  endtask

  task automatic reset_abort_test();
    rd_enM = 1'b1; wr_enM = 1'b0; funct3M = F3_W; ALUResultM = 32'h300; rdata2M = $urandom;
    push_bus(1'b0, F3_W, 32'h300, 32'h0);
    @(posedge clk); #1;            // REQ, first cycle
    @(posedge clk); #1;            // REQ, second cycle
    check("rst_pre_req", 69'(dmem_req), 69'(1));
    rst = 1'b1; rd_enM = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_state", 69'(state_dbg), 69'(IDLE));
    check("rst_req", 69'(dmem_req), 69'(0));
    check("rst_stall", 69'(stallM), 69'(0));
    @(posedge clk); #1;            // late ack still high, must be ignored
    check("late_ack_state", 69'(state_dbg), 69'(IDLE));
    check("late_ack_req", 69'(dmem_req), 69'(0));
    check("late_ack_stall", 69'(stallM), 69'(0));
    check("late_ack_rdata", 69'(rdata), 69'(0));
    dmem_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  f3;
    logic        rd, wr;
    int          op;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_state", 69'(state_dbg), 69'(IDLE));
    check("reset_req", 69'(dmem_req), 69'(0));
    check("reset_stall", 69'(stallM), 69'(0));
    check("reset_bus_err", 69'(bus_errM), 69'(0));
    check("reset_rdata", 69'(rdata), 69'(0));

    do_access(1, 0, F3_W,  32'h100, 32'h0,        0, 0, 32'hDEAD_BEEF);
    do_access(1, 0, F3_B,  32'h103, 32'h0,        1, 0, 32'h80FF_FFFF);
    do_access(1, 0, F3_BU, 32'h103, 32'h0,        2, 0, 32'h80FF_FFFF);
    do_access(1, 0, F3_HU, 32'h102, 32'h0,        0, 0, 32'h8001_0000);
    do_access(1, 0, F3_H,  32'h102, 32'h0,        0, 0, 32'h8001_0000);
    do_access(0, 1, F3_B,  32'h201, 32'h0000_00AB, 0, 0, 32'h0);
    do_access(0, 1, F3_H,  32'h202, 32'h1234_CDEF, 1, 0, 32'h0);
    do_access(0, 1, F3_W,  32'h204, 32'hCAFE_F00D, 0, 0, 32'h0);
    do_access(1, 0, F3_W,  32'h102, 32'h0,        0, 0, 32'h0);
    do_access(0, 1, F3_H,  32'h203, 32'h5555,     0, 0, 32'h0);
    do_access(1, 0, F3_W,  32'h110, 32'h0,        0, 1, 32'h0);       // timeout
    do_access(1, 0, F3_W,  32'h114, 32'h0,        TIMEOUT - 1, 0, 32'hA5A5_5A5A); // ack on last cycle
    do_access(1, 0, F3_W,  32'h118, 32'h0,        TIMEOUT, 0, 32'h1111_2222);     // one cycle too late
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    do_access(0, 0, F3_W,  32'h0,   32'h0,        0, 0, 32'h0);       // ack with no access
    dmem_ack = 1'b0;
    reset_abort_test();
    do_access(1, 0, F3_W,  32'h120, 32'h0,        0, 0, 32'h0BAD_F00D);

    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 8);
      rd = (op <= 4);
      wr = (op >= 5 && op <= 7);
      case (op)
        0: f3 = F3_B;  1: f3 = F3_H;  2: f3 = F3_W;  3: f3 = F3_BU; 4: f3 = F3_HU;
        5: f3 = F3_B;  6: f3 = F3_H;  default: f3 = F3_W;
      endcase
      do_access(rd, wr, f3, $urandom, $urandom, $urandom_range(0, 5),
                $urandom_range(0, 9) == 0, $urandom);
    end

    repeat (2) @(posedge clk);
    check("bus_q_drained", 69'(bus_q.size()), 69'(0));
    check("ret_q_drained", 69'(ret_q.size()), 69'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
